// File: rtl/quad_pkg.sv
// Shared constants and Gray-code step decode for the quadrature decoder.
// Decode states are {A,B}; counting up walks 00,10,11,01.
package quad_pkg;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_01 = 2'b01;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } quad_dec_t;

  function automatic logic [1:0] next_up(
    input logic [1:0] s
  );
    logic [1:0] n;
    case (s)
      ST_00:   n = ST_10;
      ST_10:   n = ST_11;
      ST_11:   n = ST_01;
      ST_01:   n = ST_00;
      default: n = ST_00;
    endcase
    return n;
  endfunction

  function automatic quad_dec_t quad_decode(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    quad_dec_t d;
    d = '0;
    unique case (1'b1)
      (prev == cur): ;
      ((prev ^ cur) == 2'b11): d.illegal = 1'b1;
      default: begin
        d.valid = 1'b1;
        d.up    = (cur == next_up(prev));
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// Synchroniser chain plus run-length stability filter for one
// asynchronous encoder line.
module quad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int RW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [RW-1:0]          run;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      run  <= '0;
      dout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      if (synced == dout) begin
        run <= '0;
      end else if (run == RW'(FILT_LEN - 1)) begin
        dout <= synced;
        run  <= '0;
      end else begin
        run <= run + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature position counter with index capture, illegal-transition
// flag and windowed saturating velocity.
module quad_decoder #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int VEL_PERIOD  = 1000000,
  parameter int VEL_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 quadA,
  input  logic                 quadB,
  input  logic                 index,
  input  logic                 clear,
  input  logic                 err_clear,
  output logic [WIDTH-1:0]     count,
  output logic                 dir,
  output logic                 step,
  output logic                 err,
  output logic [WIDTH-1:0]     index_pos,
  output logic                 index_seen,
  output logic [VEL_WIDTH-1:0] velocity,
  output logic                 vel_valid
);

  import quad_pkg::*;

  localparam int ARM_CYC = SYNC_STAGES + FILT_LEN + 1;
  localparam int ARM_W   = $clog2(ARM_CYC);
  localparam int TW      = $clog2(VEL_PERIOD);
  localparam int CW      = $clog2(VEL_PERIOD + 1) + 2;
  localparam int AW      = (CW > VEL_WIDTH + 1) ? CW : VEL_WIDTH + 1;
  localparam int PADW    = AW - VEL_WIDTH + 1;

  localparam logic signed [AW-1:0] VMAX =
    {{PADW{1'b0}}, {(VEL_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] VMIN =
    {{PADW{1'b1}}, {(VEL_WIDTH-1){1'b0}}};
  localparam logic signed [AW-1:0] ONE = AW'(1);

  logic                 a_f, b_f, i_f;
  logic [1:0]           ab_prev;
  logic                 i_prev;
  logic                 armed;
  logic [ARM_W-1:0]     arm_cnt;
  quad_dec_t            dec;
  logic                 take_step;
  logic [WIDTH-1:0]     count_nx;
  logic signed [AW-1:0] acc, acc_nx;
  logic [VEL_WIDTH-1:0] vel_nx;
  logic [TW-1:0]        tmr;
  logic                 win_end;

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_fa (
    .clk(clk), .reset(reset), .din(quadA), .dout(a_f)
  );
  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_fb (
    .clk(clk), .reset(reset), .din(quadB), .dout(b_f)
  );
  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_fi (
    .clk(clk), .reset(reset), .din(index), .dout(i_f)
  );

  assign dec       = quad_decode(ab_prev, {a_f, b_f});
  assign take_step = armed & dec.valid;
  assign win_end   = (tmr == TW'(VEL_PERIOD - 1));

  // clear wins over a same-cycle step in both count and accumulator
  always_comb begin
    count_nx = count;
    acc_nx   = acc;
    if (take_step) begin
      count_nx = dec.up ? count + 1'b1 : count - 1'b1;
      acc_nx   = dec.up ? acc + ONE : acc - ONE;
    end
    if (clear) begin
      count_nx = '0;
      acc_nx   = '0;
    end
    if (acc_nx > VMAX) begin
      vel_nx = VMAX[VEL_WIDTH-1:0];
    end else if (acc_nx < VMIN) begin
      vel_nx = VMIN[VEL_WIDTH-1:0];
    end else begin
      vel_nx = acc_nx[VEL_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ab_prev    <= '0;
      i_prev     <= 1'b0;
      armed      <= 1'b0;
      arm_cnt    <= '0;
      count      <= '0;
      dir        <= DOWN;
      step       <= 1'b0;
      err        <= 1'b0;
      index_pos  <= '0;
      index_seen <= 1'b0;
      velocity   <= '0;
      vel_valid  <= 1'b0;
      acc        <= '0;
      tmr        <= '0;
    end else begin
      ab_prev <= {a_f, b_f};
      i_prev  <= i_f;
      if (!armed) begin
        if (arm_cnt == ARM_W'(ARM_CYC - 1)) armed <= 1'b1;
        else arm_cnt <= arm_cnt + 1'b1;
      end
      step  <= take_step;
      count <= count_nx;
      if (take_step) dir <= dec.up ? UP : DOWN;
      if (armed && i_f && !i_prev) begin
        index_pos  <= count_nx;
        index_seen <= 1'b1;
      end
      if (armed && dec.illegal) err <= 1'b1;
      else if (err_clear) err <= 1'b0;
      vel_valid <= win_end;
      if (win_end) begin
        tmr      <= '0;
        acc      <= '0;
        velocity <= vel_nx;
      end else begin
        tmr <= tmr + 1'b1;
        acc <= acc_nx;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: step scoreboard, decode vector table and
// hand-written index, clear and velocity-window sequences.
module tb_quad_decoder;

  localparam int W   = 32;
  localparam int VP  = 100;
  localparam int VW  = 4;
  localparam int LAT = 7;

  logic          clk = 1'b0;
  logic          reset, quadA, quadB, index, clear, err_clear;
  logic [W-1:0]  count, index_pos;
  logic          dir, step, err, index_seen, vel_valid;
  logic [VW-1:0] velocity;

  quad_decoder #(
    .WIDTH(W), .SYNC_STAGES(2), .FILT_LEN(4),
    .VEL_PERIOD(VP), .VEL_WIDTH(VW)
  ) dut (
    .clk(clk), .reset(reset), .quadA(quadA), .quadB(quadB),
    .index(index), .clear(clear), .err_clear(err_clear),
    .count(count), .dir(dir), .step(step), .err(err),
    .index_pos(index_pos), .index_seen(index_seen),
    .velocity(velocity), .vel_valid(vel_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [W-1:0] cnt;
    logic         dir;
  } exp_t;

  typedef struct {
    logic         a;
    logic         b;
    logic         eclr;
    logic         exp_err;
    logic [W-1:0] exp_cnt;
  } vec_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  int           nsteps = 0;
  logic         ma, mb;
  logic [W-1:0] mcount;
  logic [1:0]   gs[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && step) begin
      nsteps++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_step: cyc %0d count %0h", cyc, count);
      end else begin
        mon_e = sbq.pop_front();
        chk("step_count", count, mon_e.cnt);
        chk("step_dir", W'(dir), W'(mon_e.dir));
        chk("step_latency", W'(cyc), W'(mon_e.due));
      end
    end
  end

  function automatic int gidx(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic a, input logic b, input logic clr);
    int   d;
    exp_t e;
    d = (gidx(a, b) - gidx(ma, mb)) & 3;
    quadA = a;
    quadB = b;
    ma = a;
    mb = b;
    if (d == 1 || d == 3) begin
      if (clr) mcount = '0;
      else if (d == 1) mcount = mcount + W'(1);
      else mcount = mcount - W'(1);
      e.due = cyc + LAT;
      e.cnt = mcount;
      e.dir = (d == 1);
      sbq.push_back(e);
    end
  endtask

  task automatic step_dir(input logic up, input logic clr);
    int i;
    i = (gidx(ma, mb) + (up ? 1 : 3)) & 3;
    drive(gs[i][1], gs[i][0], clr);
  endtask

  task automatic wait_vel(output int at);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 150 && !found; k++) begin
      @(negedge clk);
      found = vel_valid;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL vel_timeout: got none want vel_valid in 150");
    end
    at = cyc;
  endtask

  initial begin
    vec_t tbl[8];
    int   v, v2, n0;

    gs[0] = 2'b00; gs[1] = 2'b10; gs[2] = 2'b11; gs[3] = 2'b01;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h1};

    reset = 1'b1; quadA = 1'b1; quadB = 1'b0; index = 1'b0;
    clear = 1'b0; err_clear = 1'b0;
    ma = 1'b1; mb = 1'b0; mcount = '0;
    tick(3);
    reset = 1'b0;
    tick(20);
    chk("rst_count", count, '0);
    chk("rst_err", W'(err), '0);
    chk("rst_dir", W'(dir), '0);
    chk("rst_steps", W'(nsteps), '0);
    chk("rst_index_seen", W'(index_seen), '0);
    chk("rst_index_pos", index_pos, '0);
    chk("rst_velocity", W'(velocity), '0);

    n0 = nsteps;
    for (int i = 0; i < 32; i++) begin
      step_dir(1'b1, 1'b0);
      tick(20);
    end
    chk("up32_count", count, W'(32));
    chk("up32_dir", W'(dir), W'(1));
    chk("up32_steps", W'(nsteps - n0), W'(32));

    clear = 1'b1; tick(1); clear = 1'b0; mcount = '0; tick(2);
    chk("clear_count", count, '0);
    step_dir(1'b0, 1'b0); tick(10);
    chk("wrap_down", count, 32'hFFFF_FFFF);
    chk("wrap_down_dir", W'(dir), '0);
    step_dir(1'b1, 1'b0); tick(10);
    chk("wrap_up", count, '0);

    n0 = nsteps;
    quadA = ~ma; tick(2); quadA = ma; tick(12);
    chk("glitch_count", count, '0);
    chk("glitch_steps", W'(nsteps - n0), '0);
    chk("glitch_err", W'(err), '0);

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].a, tbl[i].b, 1'b0);
      tick(6);
      err_clear = tbl[i].eclr;
      tick(1);
      err_clear = 1'b0;
      tick(4);
      chk($sformatf("vec%0d_count", i), count, tbl[i].exp_cnt);
      chk($sformatf("vec%0d_err", i), W'(err), W'(tbl[i].exp_err));
    end

    chk("pre_index_seen", W'(index_seen), '0);
    clear = 1'b1; tick(1); clear = 1'b0; mcount = '0; tick(1);
    for (int i = 0; i < 56; i++) begin
      step_dir(1'b1, 1'b0);
      tick(8);
    end
    index = 1'b1;
    step_dir(1'b1, 1'b0);
    tick(LAT);
    chk("index_pos", index_pos, W'(57));
    chk("index_seen", W'(index_seen), W'(1));
    chk("index_count", count, W'(57));
    index = 1'b0;
    tick(10);

    step_dir(1'b1, 1'b1);
    tick(6); clear = 1'b1; tick(1); clear = 1'b0; tick(3);
    chk("clear_step_count", count, '0);
    chk("clear_keeps_index", index_pos, W'(57));

    wait_vel(v);
    for (int i = 0; i < 5; i++) begin step_dir(1'b1, 1'b0); tick(8); end
    wait_vel(v2);
    chk("vel_period1", W'(v2 - v), W'(VP));
    chk("vel_up5", W'(velocity), W'(5));
    v = v2;
    for (int i = 0; i < 10; i++) begin step_dir(1'b1, 1'b0); tick(8); end
    wait_vel(v2);
    chk("vel_period2", W'(v2 - v), W'(VP));
    chk("vel_up10_sat", W'(velocity), W'(7));
    v = v2;
    for (int i = 0; i < 12; i++) begin step_dir(1'b0, 1'b0); tick(7); end
    wait_vel(v2);
    chk("vel_period3", W'(v2 - v), W'(VP));
    chk("vel_dn12_sat", W'(velocity), W'(4'h8));
    v = v2;
    tick(VP - LAT);
    step_dir(1'b1, 1'b0);
    wait_vel(v2);
    chk("vel_period4", W'(v2 - v), W'(VP));
    chk("vel_last_cycle", W'(velocity), W'(1));
    tick(1);
    chk("vel_valid_pulse", W'(vel_valid), '0);
    v = v2;
    wait_vel(v2);
    chk("vel_idle", W'(velocity), '0);

    tick(10);
    chk("sb_drained", W'(sbq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
